// File: rtl/avr_pkg.sv
// Shared constants and state encoding for the AVR data-memory responder.
package avr_pkg;

    localparam logic [15:0] AVR_SRAM_BASE_DEF = 16'h0060;
    localparam logic [15:0] AVR_IO_LO         = 16'h0020;
    localparam logic [15:0] AVR_IO_HI         = 16'h005F;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_READY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/avr_sram_1rw.sv
// Single-port synchronous SRAM, DEPTH x 8, write-first registered read port.
module avr_sram_1rw #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [DEPTH];
    logic [7:0] dout_q;
    logic [7:0] dout_d;

    // Write-first: a write returns the new byte on dout
    always_comb begin
        dout_d = we ? din : mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/avr_dmem_responder.sv
// AVR data-memory bus target: SRAM window decode, registered reads on the
// shared bus, zero-fill clear sequencer and sticky out-of-range flag.
module avr_dmem_responder
    import avr_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [15:0] SRAM_BASE = AVR_SRAM_BASE_DEF,
    parameter logic [7:0]  FILL      = 8'h00,
    parameter logic [7:0]  OOB_RD    = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] d_addr,
    inout  wire  [7:0]  data,
    input  logic        data_write,
    input  logic        clr_req,
    output logic        busy,
    output logic        oob
);

    localparam int            AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [16:0]   END_A = {1'b0, SRAM_BASE} + 17'(DEPTH);

    dm_state_e     state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          sel_q, sel_d;
    logic          oob_q, oob_d;

    logic          is_low, is_in, is_high;
    logic [AW-1:0] off_idx;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic [7:0]    rdata;
    logic          drive;

    assign off_idx = AW'(d_addr - SRAM_BASE);
    assign is_low  = d_addr < SRAM_BASE;
    assign is_in   = !is_low && ({1'b0, d_addr} < END_A);
    assign is_high = !is_low && !is_in;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rdata_d   = rdata_q;
        sel_d     = sel_q;
        oob_d     = oob_q;
        ram_we    = 1'b0;
        ram_addr  = off_idx;
        ram_din   = data;
        unique case (state_q)
            DM_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_din   = FILL;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d = DM_READY;
                end
            end
            DM_READY: begin
                if (is_in) begin
                    ram_we = data_write;
                    sel_d  = 1'b1;
                end else if (!data_write) begin
                    sel_d   = 1'b0;
                    rdata_d = is_low ? 8'h00 : OOB_RD;
                end
                if (is_high) begin
                    oob_d = 1'b1;
                end
            end
            default: state_d = DM_CLEAR;
        endcase
        // A clear request drops whatever access shares its cycle
        if (clr_req) begin
            state_d   = DM_CLEAR;
            clr_cnt_d = '0;
            ram_we    = state_q == DM_CLEAR;
            rdata_d   = rdata_q;
            sel_d     = sel_q;
            oob_d     = oob_q;
        end
        if (!RST_N) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= DM_CLEAR;
            clr_cnt_q <= '0;
            rdata_q   <= FILL;
            sel_q     <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            sel_q     <= sel_d;
            oob_q     <= oob_d;
        end
    end

    avr_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    assign rdata = sel_q ? ram_dout : rdata_q;
    assign drive = (state_q == DM_READY) && !data_write;
    assign data  = drive ? rdata : 8'bz;
    assign busy  = state_q == DM_CLEAR;
    assign oob   = oob_q;

endmodule

// File: tb/tb_avr_dmem_responder.sv
// Randomized and directed bench for avr_dmem_responder against a byte-array model.
module tb_avr_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int BASE  = 'h60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_write = 1'b0;
    logic        clr_req = 1'b0;
    logic        tb_drv = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [7:0]  tb_wdata = 8'h00;
    wire  [7:0]  data;
    logic        busy;
    logic        oob;

    int n_cmp = 0;
    int n_bad = 0;

    assign data = tb_drv ? tb_wdata : 8'bz;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    always #5 clk = ~clk;

    avr_dmem_responder dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .d_addr     (d_addr),
        .data       (data),
        .data_write (data_write),
        .clr_req    (clr_req),
        .busy       (busy),
        .oob        (oob)
    );

    // Behavioural model: byte array plus clear countdown
    logic [7:0] mmem [DEPTH];
    bit         m_live = 1'b0;
    bit         m_busy = 1'b1;
    bit         m_oob = 1'b0;
    bit         m_ev = 1'b0;
    logic [7:0] m_exp = 8'h00;
    int         m_cnt = 0;

    always @(posedge clk) begin
        int a;
        a = int'(d_addr);
        if (!rst_n) begin
            m_live <= 1'b1;
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_oob  <= 1'b0;
            m_ev   <= 1'b0;
        end else if (clr_req) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_ev   <= 1'b0;
        end else if (m_busy) begin
            mmem[m_cnt] <= 8'h00;
            m_cnt       <= m_cnt + 1;
            m_ev        <= 1'b0;
            if (m_cnt == DEPTH - 1) m_busy <= 1'b0;
        end else if (data_write) begin
            m_ev <= 1'b0;
            if (a >= BASE && a < BASE + DEPTH) mmem[a - BASE] <= tb_wdata;
            if (a >= BASE + DEPTH) m_oob <= 1'b1;
        end else begin
            m_ev <= 1'b1;
            if (a < BASE) m_exp <= 8'h00;
            else if (a < BASE + DEPTH) m_exp <= mmem[a - BASE];
            else begin
                m_exp <= 8'hFF;
                m_oob <= 1'b1;
            end
        end
    end

    task automatic check8(input string nm, input logic [7:0] act,
                          input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (m_live) begin
            check8("busy", {7'b0, busy}, {7'b0, m_busy});
            check8("oob", {7'b0, oob}, {7'b0, m_oob});
            if (data_write) begin
                tb_drv = 1'b0;
                #1;
                check8("hiz_wr", data, 8'hFF);
                tb_drv = 1'b1;
            end else if (m_busy) begin
                check8("hiz_busy", data, 8'hFF);
            end else if (m_ev) begin
                check8("rdata", data, m_exp);
            end
        end
    endtask

    task automatic step(input bit w, input logic [15:0] a,
                        input logic [7:0] wd, input bit clr, input bit r);
        @(posedge clk);
        #1;
        rst_n      = r;
        d_addr     = a;
        data_write = w;
        tb_wdata   = wd;
        tb_drv     = w;
        clr_req    = clr;
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, a, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            rd(16'h0000);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] last_a;
        int sel;

        // Reset and initial clear
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        count_busy(n);
        check8("t1_busy_len_lo", n[7:0], 8'h00);
        check8("t1_busy_len_hi", n[15:8], 8'h04);
        check8("t1_oob_reset", {7'b0, oob}, 8'h00);
        rd(16'h0060);
        rd(16'h045F);
        check8("t1_rd_0060", data, 8'h00);
        rd(16'h0000);
        check8("t1_rd_045F", data, 8'h00);

        // Write then read back
        wr(16'h0100, 8'hA5);
        rd(16'h0100);
        rd(16'h0000);
        check8("t2_rd_0100", data, 8'hA5);

        // Register/IO space below the window
        rd(16'h005F);
        rd(16'h0000);
        check8("t4_rd_005F", data, 8'h00);
        check8("t4_oob", {7'b0, oob}, 8'h00);
        wr(16'h005F, 8'h77);
        rd(16'h0060);
        rd(16'h0000);
        check8("t4_rd_0060", data, 8'h00);

        // Top edge of window and just above it
        wr(16'h045F, 8'h3C);
        rd(16'h045F);
        rd(16'h0460);
        check8("t3_rd_045F", data, 8'h3C);
        rd(16'h0000);
        check8("t3_rd_0460", data, 8'hFF);
        check8("t3_oob_set", {7'b0, oob}, 8'h01);
        rd(16'h0100);
        rd(16'h0000);
        check8("t3_oob_sticky", {7'b0, oob}, 8'h01);

        // Back-to-back frame writes and reads
        wr(16'h0200, 8'h12);
        wr(16'h01FF, 8'h34);
        rd(16'h0200);
        rd(16'h01FF);
        check8("t5_rd_0200", data, 8'h12);
        rd(16'h0000);
        check8("t5_rd_01FF", data, 8'h34);

        // Clear request, then reset in the middle of the clear
        step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 499; k++) rd(16'h0000);
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        count_busy(n);
        check8("t6_busy_len_lo", n[7:0], 8'h00);
        check8("t6_busy_len_hi", n[15:8], 8'h04);
        check8("t6_oob_reset", {7'b0, oob}, 8'h00);
        rd(16'h0100);
        rd(16'h0000);
        check8("t6_rd_0100", data, 8'h00);

        // Randomized traffic, biased to window edges and address reuse
        last_a = 16'h0100;
        for (int k = 0; k < 5000; k++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1: a = 16'(BASE) + 16'($urandom_range(0, DEPTH - 1));
                2: a = 16'(BASE - 1);
                3: a = 16'(BASE + DEPTH);
                4: a = 16'(BASE + DEPTH - 1);
                5: a = 16'(BASE);
                6: a = 16'($urandom());
                default: a = last_a;
            endcase
            last_a = a;
            if ($urandom_range(0, 1999) == 0) begin
                step(1'b0, a, 8'h00, 1'b0, 1'b0);
            end else begin
                step($urandom_range(0, 9) < 4, a, 8'($urandom()),
                     $urandom_range(0, 1499) == 0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
